// File: rtl/psa_accum.sv
// Packed-nibble saturating accumulator: sums a burst of 16-bit words as four
// independent signed 4-bit lanes, with sticky per-lane saturation flags.
module psa_accum #(
    parameter int LEN_W = 4,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic [3:0]       lane_ovfl,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for start; accumulator holds the last result
    // ACCUM | accepting one word per cycle until remaining reaches zero
    // DONE  | result presented on out_valid until the consumer takes it
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [3:0]       ovfl_q, ovfl_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    logic [15:0]      sat_sum;
    logic [3:0]       sat_ovf;

    // Each lane is an isolated 4-bit signed add; no carry crosses a nibble.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [3:0] a, b, s;
        logic       ov;
        assign a  = acc_q[4*g +: 4];
        assign b  = in_data[4*g +: 4];
        assign s  = a + b;
        assign ov = (a[3] == b[3]) && (s[3] != a[3]);
        assign sat_sum[4*g +: 4] = ov ? (a[3] ? 4'h8 : 4'h7) : s;
        assign sat_ovf[g]        = ov;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovfl_d    = ovfl_q;
        rem_d     = rem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d  = '0;
                    ovfl_d = '0;
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = S_ACCUM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d  = sat_sum;
                    ovfl_d = ovfl_q | sat_ovf;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovfl_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovfl_q  <= ovfl_d;
            rem_q   <= rem_d;
        end
    end

    assign result    = acc_q;
    assign lane_ovfl = ovfl_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_psa_accum.sv
// Scoreboard bench for psa_accum: bursts are driven with random gaps, expected
// results come from an integer lane model and are checked at each output handshake.
module tb_psa_accum;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n, start, in_valid, out_ready;
    logic [LEN_W-1:0] len;
    logic [15:0]      in_data;
    logic             in_ready, out_valid, busy;
    logic [15:0]      result;
    logic [3:0]       lane_ovfl;

    psa_accum #(.LEN_W(LEN_W), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .lane_ovfl(lane_ovfl), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  ov;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lanes as plain integers, clamped to [-8,7]; a clamp sets that lane's flag.
    function automatic exp_t model(input logic [15:0] w[$]);
        int         lane[4];
        int         v, s;
        logic [3:0] f;
        exp_t       e;
        for (int i = 0; i < 4; i++) lane[i] = 0;
        f = '0;
        foreach (w[k]) begin
            for (int i = 0; i < 4; i++) begin
                v = $signed(w[k][4*i +: 4]);
                s = lane[i] + v;
                if (s > 7) begin s = 7; f[i] = 1'b1; end
                else if (s < -8) begin s = -8; f[i] = 1'b1; end
                lane[i] = s;
            end
        end
        for (int i = 0; i < 4; i++) e.res[4*i +: 4] = 4'(lane[i]);
        e.ov = f;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: output result=%0h with no expected entry", result);
            end else begin
                m_e = sb.pop_front();
                chk("sb_result", 32'(result), 32'(m_e.res));
                chk("sb_lane_ovfl", 32'(lane_ovfl), 32'(m_e.ov));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_burst(input logic [15:0] w[$], input int gap_pct,
                            input int hold, input bit start_in_hold);
        int   n, k, cyc;
        bit   got;
        exp_t e;
        n = w.size();
        e = model(w);
        sb.push_back(e);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 200) begin
            chk("out_valid_in_accum", 32'(out_valid), 32'd0);
            chk("in_ready_accum", 32'(in_ready), 32'd1);
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = w[k];
            end
            got = in_valid && in_ready;
            tick();
            if (got) k++;
            cyc++;
        end
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: accepted %0d of %0d beats", k, n);
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        chk("out_valid_latency", 32'(out_valid), 32'd1);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            start = start_in_hold;
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'(result), 32'(e.res));
            chk("hold_lane_ovfl", 32'(lane_ovfl), 32'(e.ov));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        start     = start_in_hold;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        tick();
        chk("idle_stays", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q[$];
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_lane_ovfl", 32'(lane_ovfl), 32'd0);
        rst_n = 1'b1;
        tick();

        q = {16'h1234, 16'h1111};          do_burst(q, 0, 0, 0);
        q = {16'h7000, 16'h1000};          do_burst(q, 0, 1, 0);
        q = {16'h0007, 16'h0001, 16'h000F}; do_burst(q, 0, 0, 0);
        q = {16'h8888, 16'hFFFF};          do_burst(q, 0, 2, 0);
        q = {};                            do_burst(q, 0, 0, 0);
        q = {16'h3333, 16'h2222, 16'h1111}; do_burst(q, 50, 4, 1);

        // Reset in the middle of a burst discards everything, no output pulse.
        start = 1'b1;
        len   = LEN_W'(3);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        q = {16'h0101};                    do_burst(q, 0, 0, 0);

        for (int b = 0; b < 30; b++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(15)); i++) q.push_back(16'($urandom));
            do_burst(q, 30, int'($urandom_range(3)), bit'($urandom_range(1)));
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/psa_accum.md
Name: psa_accum

Overview:
- Sequential packed-nibble saturating accumulator in the execute stage, downstream of the 16-bit parallel sub-word adder.
- Consumes a burst of packed 16-bit words (four signed 4-bit lanes) over a valid/ready handshake.
- Keeps a running per-lane signed saturating sum and sticky per-lane overflow flags.
- Presents the final packed result on an output valid/ready handshake.

Parameters:
- LEN_W, 4, width of the burst-length input; maximum burst is 2^LEN_W-1 words.
- LANES, 4, number of 4-bit lanes. Fixed at 4 for a 16-bit word; not to be overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new burst; sampled only in IDLE.
- len  input  LEN_W  number of words in the burst; sampled with start.
- in_valid  input  1  in_data holds a valid word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  16  packed word: lane3=[15:12], lane2=[11:8], lane1=[7:4], lane0=[3:0].
- out_valid  output  1  result and lane_ovfl are valid.
- out_ready  input  1  consumer takes the result.
- result  output  16  packed accumulated sum.
- lane_ovfl  output  4  sticky saturation flag per lane; bit i corresponds to lane i.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - acc=0x0000, ovfl=4'b0000, remaining=0.
  - Outputs: in_ready=0, out_valid=0, busy=0, result=0x0000, lane_ovfl=0.
- Registered outputs: result=acc, lane_ovfl=ovfl.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - If start=1 and len!=0: acc<=0, ovfl<=0, remaining<=len; go to ACCUM.
  - If start=1 and len==0: acc<=0, ovfl<=0; go to DONE (empty burst).
- ACCUM:
  - in_ready=1.
  - On a beat (in_valid & in_ready):
    - acc<=satadd(acc,in_data).
    - ovfl<=ovfl | lane overflow of this add.
    - remaining<=remaining-1.
  - If the beat occurs with remaining==1, go to DONE.
  - If in_valid=0, hold all state; no timeout.
- DONE:
  - out_valid=1, in_ready=0.
  - Hold result/lane_ovfl stable until out_ready=1.
  - On out_valid & out_ready, go to IDLE. acc and ovfl keep their values; they clear on the next start.
- Lane arithmetic: each lane is independent 4-bit two's complement; no carry crosses lane boundaries.
  - Overflow occurs when both operands have the same sign and the raw 4-bit sum's sign differs.
  - Positive overflow saturates to 0x7; negative overflow saturates to 0x8.
  - Without overflow, the lane takes the raw 4-bit sum.
  - Saturation is not sticky on the value: later adds operate on the saturated value. Only the flag is sticky.
- Latency: out_valid asserts on the cycle after the final accepted beat. For len=0 it asserts the cycle after start.
- Throughput: one word per cycle in ACCUM.
- start outside IDLE is ignored, including start and out_ready in the same DONE cycle. A new burst needs start in IDLE, so there is a minimum 1-cycle gap between bursts.
- len is captured only at start; later changes to len have no effect.
- Reset mid-burst discards the partial sum. No output pulse is produced.
- in_data is ignored whenever in_ready=0.

Test Plan:
- len=2; beats 0x1234 then 0x1111 -> one cycle after 2nd beat: out_valid=1, result=0x2345, lane_ovfl=4'b0000.
- len=2; beats 0x7000 then 0x1000 -> result=0x7000, lane_ovfl=4'b1000. Then len=3 with 0x0007, 0x0001, 0x000F -> lane0: 7, sat 7, 6; result=0x0006, lane_ovfl=4'b0001.
- len=2; beats 0x8888 then 0xFFFF -> every lane -8 + -1 saturates: result=0x8888, lane_ovfl=4'b1111.
- len=0 with start -> next cycle out_valid=1, result=0x0000, lane_ovfl=0, no beats accepted.
- Backpressure and idle input:
  - len=3 with in_valid toggling 1,0,0,1,1 -> exactly 3 beats accepted, in_ready=1 throughout ACCUM.
  - Hold out_ready=0 for 4 cycles in DONE -> out_valid and result stable, in_ready=0, start pulses ignored.
  - Release out_ready -> IDLE next cycle.
- Assert rst_n=0 mid-ACCUM after 1 of 3 beats -> immediately in_ready=0, out_valid=0, busy=0, result=0x0000.
  - A following len=1 burst of 0x0101 yields result=0x0101.
